tx_sequencer: RTL and testbench
===============================

Name: tx_sequencer

Overview:
Output-side sequencer for the binary calculator. When the controller asserts TxData, it captures a result frame in parallel: ALU result plus flags, or a memory read word in memory mode. It shifts the frame out serially MSB-first with a valid strobe, optionally followed by an even-parity bit. It then returns a one-cycle TxDone to the controller, which closes the controller's TxData/TxDone handshake.

Parameters:
DATA_W, 8, width of ALU result and memory data word
FLAG_W, 4, width of ALU flag field
PARITY_EN, 1, 1 = append an even-parity bit after the frame LSB; 0 = no parity bit

Ports:
Clk  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high reset
TxData  in  1  start request from controller, level or pulse; sampled only in IDLE
Mode  in  1  0 = calculator mode, 1 = memory mode; sampled with TxData
ResultIn  in  DATA_W  ALU result
FlagsIn  in  FLAG_W  ALU flags
MemDataIn  in  DATA_W  memory read data
DOut  out  1  serial data bit
DOutValid  out  1  high while DOut carries a frame or parity bit
TxBusy  out  1  high from the cycle after capture until TxDone inclusive
TxDone  out  1  one-cycle completion pulse to controller

Behaviour:
- Reset asynchronous, active-high. Outputs during and after reset: DOut=0, DOutValid=0, TxBusy=0, TxDone=0. State=IDLE, shift register=0, bit counter=0, parity accumulator=0. Reset mid-frame aborts the frame silently; no TxDone is produced.
- FRAME_W = FLAG_W + DATA_W. Bit counter width = $clog2(FRAME_W+1).
- States: IDLE, SHIFT, PARITY, DONE.
- IDLE, on TxData=1 at edge k: capture the frame and go to SHIFT.
  - Mode=0: frame = {FlagsIn, ResultIn}.
  - Mode=1: frame = {FLAG_W'b0, MemDataIn}.
  - Load counter = FRAME_W; clear parity accumulator.
- SHIFT: each cycle DOut = shift_reg MSB and DOutValid=1.
  - Each edge: shift left by one, XOR DOut into parity, decrement counter.
  - After FRAME_W bits: go to PARITY if PARITY_EN=1, else to DONE.
- PARITY: one cycle. DOut = accumulated XOR of all frame bits (even parity), DOutValid=1. Next state DONE.
- DONE: one cycle. TxDone=1, DOutValid=0, DOut=0, TxBusy=1. Next state IDLE.
- Latency: first bit is on DOut in cycle k+1. TxDone is high in cycle k+1+FRAME_W+PARITY_EN.
- Back-to-back: TxData still high in the cycle after DONE (now IDLE) starts a new frame. Minimum gap between frames is one IDLE cycle with DOutValid=0.
- TxData is ignored in SHIFT, PARITY and DONE; no queuing. Input changes after capture do not affect the frame in flight.
- Mode or data changing in the same cycle as TxData: the values present at the capture edge are the ones used.
- Outputs are registered, except DOut, which is driven directly from the shift register MSB or the parity register.
- TxBusy = (state != IDLE).

Decomposition:
- Package tx_pkg holds:
  - tx_state_t enum {IDLE, SHIFT, PARITY, DONE}
  - default DATA_W/FLAG_W constants
  - frame-width function FRAME_W = FLAG_W + DATA_W
- One sub-module, tx_shift_reg: parallel load, shift-left enable, MSB out, running parity XOR, async reset.
- FSM and bit counter live in tx_sequencer.

Test Plan:
- Defaults, Mode=0, ResultIn=8'hA5, FlagsIn=4'h3, 1-cycle TxData pulse:
  - DOut over cycles k+1..k+12 = 0011_1010_0101 with DOutValid=1.
  - Parity bit 0 at k+13.
  - TxDone single pulse at k+14.
  - TxBusy high k+1..k+14.
- Mode=1, MemDataIn=8'h7F, ResultIn=8'hFF:
  - Bits = 0000_0111_1111, parity 1.
  - ResultIn must not appear on DOut.
- PARITY_EN=0, Mode=0, Result=8'h01, Flags=4'h0:
  - 12 bits, last bit 1.
  - TxDone at k+13, no parity cycle.
- TxData held high continuously:
  - Frames repeat with exactly one IDLE cycle (DOutValid=0, TxDone=0) between TxDone and the next first bit.
  - Extra TxData pulses during SHIFT produce no extra frame.
- Reset asserted asynchronously mid-frame at bit 5:
  - All outputs go to 0 immediately; no TxDone.
  - After release, a new TxData produces a full, correct frame.
- Inputs changed the cycle after capture (Result 8'hA5→8'h00):
  - Transmitted bits still reflect 8'hA5.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the calculator's transmit sequencer.
//   tx_state_t    : sequencer FSM states
//   DefaultDataW  : default width of ALU result / memory word
//   DefaultFlagW  : default width of ALU flag field
//   frame_w()     : serial frame width (flags + data)
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } tx_state_t;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultFlagW = 4;

  function automatic int unsigned frame_w(input int unsigned flag_w, input int unsigned data_w);
    return flag_w + data_w;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-left register with a running even-parity accumulator.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   load_i       : load load_data_i and clear the parity accumulator
//   load_data_i  : parallel frame to transmit
//   shift_i      : shift left by one, folding the outgoing MSB into parity
//   msb_o        : current MSB (bit on the wire)
//   parity_o     : XOR of every bit shifted out since the last load
module tx_shift_reg #(
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic             parity_o
);

  logic [Width-1:0] sr_q, sr_d;
  logic             par_q, par_d;

  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    if (load_i) begin
      sr_d  = load_data_i;
      par_d = 1'b0;
    end else if (shift_i) begin
      sr_d  = {sr_q[Width-2:0], 1'b0};
      par_d = par_q ^ sr_q[Width-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      par_q <= par_d;
    end
  end

  assign msb_o    = sr_q[Width-1];
  assign parity_o = par_q;

endmodule

// File: rtl/tx_sequencer.sv
// Output-side sequencer: captures a result frame on TxData, shifts it out
// MSB-first with a valid strobe, optionally appends even parity, then pulses
// TxDone for one cycle.
//   Clk       : clock, rising edge
//   Reset     : asynchronous active-high reset (aborts a frame, no TxDone)
//   TxData    : start request, sampled only in IDLE
//   Mode      : 0 = {FlagsIn, ResultIn}, 1 = {zeros, MemDataIn}
//   ResultIn  : ALU result
//   FlagsIn   : ALU flags
//   MemDataIn : memory read data
//   DOut      : serial data bit
//   DOutValid : high while DOut carries a frame or parity bit
//   TxBusy    : high whenever the sequencer is not idle
//   TxDone    : one-cycle completion pulse
module tx_sequencer
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned FLAG_W    = DefaultFlagW,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TxData,
  input  logic              Mode,
  input  logic [DATA_W-1:0] ResultIn,
  input  logic [FLAG_W-1:0] FlagsIn,
  input  logic [DATA_W-1:0] MemDataIn,
  output logic              DOut,
  output logic              DOutValid,
  output logic              TxBusy,
  output logic              TxDone
);

  localparam int unsigned FRAME_W = frame_w(FLAG_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, busy_q, done_q;
  logic [FRAME_W-1:0] frame;
  logic               load, shift;
  logic               sr_msb, sr_parity;

  tx_shift_reg #(
    .Width (FRAME_W)
  ) u_shift_reg (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load),
    .load_data_i (frame),
    .shift_i     (shift),
    .msb_o       (sr_msb),
    .parity_o    (sr_parity)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    frame   = Mode ? {{FLAG_W{1'b0}}, MemDataIn} : {FlagsIn, ResultIn};
    case (state_q)
      IDLE: begin
        if (TxData) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(FRAME_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // Last frame bit is on the wire this cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = PARITY_EN ? PARITY : DONE;
        end
      end
      PARITY:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Flag outputs are registered from the next state so they line up with it.
      valid_q <= (state_d == SHIFT) || (state_d == PARITY);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // DOut is intentionally combinational from the shift/parity registers.
  always_comb begin
    DOut = 1'b0;
    if (state_q == SHIFT) begin
      DOut = sr_msb;
    end else if (state_q == PARITY) begin
      DOut = sr_parity;
    end
  end

  assign DOutValid = valid_q;
  assign TxBusy    = busy_q;
  assign TxDone    = done_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer: one instance with parity, one without.
module tb_tx_sequencer;

  localparam int unsigned FW = 12;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       tx_data = 1'b0;
  logic       tx_data_np = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] res = 8'h00;
  logic [3:0] flags = 4'h0;
  logic [7:0] mem = 8'h00;

  logic dout, dval, busy, done;
  logic dout_n, dval_n, busy_n, done_n;

  int total = 0;
  int bad = 0;

  // Expected per-cycle {DOut, DOutValid, TxBusy, TxDone} after the capture edge.
  logic [3:0] e_vec [16];
  int n;

  always #5 Clk = ~Clk;

  tx_sequencer #(
    .DATA_W    (8),
    .FLAG_W    (4),
    .PARITY_EN (1'b1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .TxData    (tx_data),
    .Mode      (mode),
    .ResultIn  (res),
    .FlagsIn   (flags),
    .MemDataIn (mem),
    .DOut      (dout),
    .DOutValid (dval),
    .TxBusy    (busy),
    .TxDone    (done)
  );

  tx_sequencer #(
    .DATA_W    (8),
    .FLAG_W    (4),
    .PARITY_EN (1'b0)
  ) dut_np (
    .Clk       (Clk),
    .Reset     (Reset),
    .TxData    (tx_data_np),
    .Mode      (mode),
    .ResultIn  (res),
    .FlagsIn   (flags),
    .MemDataIn (mem),
    .DOut      (dout_n),
    .DOutValid (dval_n),
    .TxBusy    (busy_n),
    .TxDone    (done_n)
  );

  function automatic logic [11:0] model_frame(input logic m, input logic [7:0] r,
                                              input logic [3:0] f, input logic [7:0] md);
    return m ? {4'h0, md} : {f, r};
  endfunction

  // Reference waveform: FW data bits, optional parity, done, one idle cycle.
  task automatic build_expect(input logic [11:0] fr, input bit par);
    n = 0;
    for (int c = 0; c < int'(FW); c++) begin
      e_vec[n] = {fr[FW-1-c], 3'b110};
      n = n + 1;
    end
    if (par) begin
      e_vec[n] = {^fr, 3'b110};
      n = n + 1;
    end
    e_vec[n] = 4'b0011;
    n = n + 1;
    e_vec[n] = 4'b0000;
    n = n + 1;
  endtask

  function automatic logic [3:0] obs(input bit np);
    return np ? {dout_n, dval_n, busy_n, done_n} : {dout, dval, busy, done};
  endfunction

  // Present inputs and raise the start request; returns just after capture edge k.
  task automatic launch(input bit np, input logic m, input logic [7:0] r,
                        input logic [3:0] f, input logic [7:0] md);
    @(negedge Clk);
    mode  = m;
    res   = r;
    flags = f;
    mem   = md;
    if (np) tx_data_np = 1'b1;
    else    tx_data    = 1'b1;
    @(posedge Clk);
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      total++;
      if ({obs(0), obs(1)} !== 8'h00) begin
        bad++;
        $display("FAIL reset_held cycle %0d: got %b want 00000000", c, {obs(0), obs(1)});
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if ({obs(0), obs(1)} !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: got %b want 00000000", {obs(0), obs(1)});
    end
  endtask

  task automatic test_calc_mode;
    launch(0, 1'b0, 8'hA5, 4'h3, 8'h00);
    build_expect(model_frame(1'b0, 8'hA5, 4'h3, 8'h00), 1'b1);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL calc_mode cycle k+%0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      if (c == 0) tx_data = 1'b0;
    end
  endtask

  task automatic test_mem_mode;
    launch(0, 1'b1, 8'hFF, 4'hF, 8'h7F);
    build_expect(model_frame(1'b1, 8'hFF, 4'hF, 8'h7F), 1'b1);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL mem_mode cycle k+%0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      if (c == 0) tx_data = 1'b0;
    end
  endtask

  task automatic test_no_parity;
    launch(1, 1'b0, 8'h01, 4'h0, 8'hC3);
    build_expect(model_frame(1'b0, 8'h01, 4'h0, 8'hC3), 1'b0);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(1) !== e_vec[c]) begin
        bad++;
        $display("FAIL no_parity cycle k+%0d: got %b want %b", c + 1, obs(1), e_vec[c]);
      end
      if (c == 0) tx_data_np = 1'b0;
    end
  endtask

  task automatic test_input_change;
    launch(0, 1'b0, 8'hA5, 4'h9, 8'h00);
    build_expect(model_frame(1'b0, 8'hA5, 4'h9, 8'h00), 1'b1);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL input_change cycle k+%0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      if (c == 0) begin
        tx_data = 1'b0;
        res     = 8'h00;
        flags   = 4'h6;
        mode    = 1'b1;
        mem     = 8'($urandom);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r, md;
    logic [3:0] f;
    logic       m;
    r  = 8'($urandom);
    md = 8'($urandom);
    f  = 4'($urandom);
    m  = 1'($urandom);
    launch(0, m, r, f, md);
    build_expect(model_frame(m, r, f, md), 1'b1);
    // First frame with TxData held: the idle cycle must still appear.
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL b2b_first cycle %0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
    end
    // Second frame starts right after the idle cycle; TxData jitter is ignored.
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL b2b_second cycle %0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      tx_data = (c < n - 1) ? 1'($urandom) : 1'b0;
    end
    @(negedge Clk);
    total++;
    if (obs(0) !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_no_extra: got %b want 0000", obs(0));
    end
  endtask

  task automatic test_abort;
    logic [7:0] r, md;
    logic [3:0] f;
    r  = 8'($urandom);
    md = 8'($urandom);
    f  = 4'($urandom);
    launch(0, 1'b0, r, f, md);
    build_expect(model_frame(1'b0, r, f, md), 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL abort_prefix cycle %0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      if (c == 0) tx_data = 1'b0;
    end
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    total++;
    if (obs(0) !== 4'b0000) begin
      bad++;
      $display("FAIL abort_immediate: got %b want 0000", obs(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== 4'b0000) begin
        bad++;
        $display("FAIL abort_in_reset cycle %0d: got %b want 0000", c, obs(0));
      end
    end
    Reset = 1'b0;
    for (int c = 0; c < int'(FW) + 3; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== 4'b0000) begin
        bad++;
        $display("FAIL abort_silent cycle %0d: got %b want 0000", c, obs(0));
      end
    end
    r = 8'($urandom);
    f = 4'($urandom);
    launch(0, 1'b0, r, f, md);
    build_expect(model_frame(1'b0, r, f, md), 1'b1);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      total++;
      if (obs(0) !== e_vec[c]) begin
        bad++;
        $display("FAIL abort_recover cycle %0d: got %b want %b", c + 1, obs(0), e_vec[c]);
      end
      if (c == 0) tx_data = 1'b0;
    end
  endtask

  task automatic test_random;
    bit         np;
    logic [7:0] r, md;
    logic [3:0] f;
    logic       m;
    for (int it = 0; it < 20; it++) begin
      np = 1'($urandom);
      r  = 8'($urandom);
      md = 8'($urandom);
      f  = 4'($urandom);
      m  = 1'($urandom);
      launch(np, m, r, f, md);
      build_expect(model_frame(m, r, f, md), !np);
      for (int c = 0; c < n; c++) begin
        @(negedge Clk);
        total++;
        if (obs(np) !== e_vec[c]) begin
          bad++;
          $display("FAIL random it %0d np %0d cycle %0d: got %b want %b",
                   it, np, c + 1, obs(np), e_vec[c]);
        end
        if (c == 0) begin
          tx_data    = 1'b0;
          tx_data_np = 1'b0;
          res        = 8'($urandom);
          flags      = 4'($urandom);
          mem        = 8'($urandom);
          mode       = 1'($urandom);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_calc_mode();
    test_mem_mode();
    test_no_parity();
    test_input_change();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
